// File: rtl/datapath_ctrl_fsm_pkg.sv
// Shared definitions for the datapath sequencer: state encoding, instruction
// opcode/op constants, instruction classes, ALU and shifter control codes.
package datapath_ctrl_fsm_pkg;

    // Controller states (3-bit encoding).
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_CMP    = 3'd5,
        S_WR_REG = 3'd6,
        S_WR_IMM = 3'd7
    } state_e;

    // Instruction opcodes (instr[15:13]).
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // op field (instr[12:11]) values.
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU control codes.
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Shifter control codes.
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    // Instruction classes; each selects a distinct path through the FSM.
    typedef enum logic [2:0] {
        K_ILLEGAL = 3'd0,
        K_MOV_IMM = 3'd1,
        K_MOV_REG = 3'd2,
        K_ALU_AB  = 3'd3,   // ADD / AND: both operands read, result written
        K_CMP     = 3'd4,
        K_MVN     = 3'd5
    } kind_e;

endpackage

// File: rtl/datapath_ctrl_fsm_instr_decode.sv
// instr_decode: combinational split of the latched instruction into fields,
// sign extension of imm8, and classification (including legality).
// Ports:
//   ir_i      in   16   latched instruction
//   op_o      out  2    op field [12:11]
//   rn_o      out  3    Rn [10:8]
//   rd_o      out  3    Rd [7:5]
//   sh_o      out  2    shift [4:3]
//   rm_o      out  3    Rm [2:0]
//   imm_sx_o  out  DW   imm8 sign-extended to DW
//   kind_o    out  3    instruction class (K_ILLEGAL when unsupported)
module instr_decode
    import datapath_ctrl_fsm_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [15:0]   ir_i,
    output logic [1:0]    op_o,
    output logic [2:0]    rn_o,
    output logic [2:0]    rd_o,
    output logic [1:0]    sh_o,
    output logic [2:0]    rm_o,
    output logic [DW-1:0] imm_sx_o,
    output kind_e         kind_o
);

    logic [2:0] opcode;

    assign opcode   = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign imm_sx_o = {{(DW-8){ir_i[7]}}, ir_i[7:0]};

    always_comb begin
        kind_o = K_ILLEGAL;
        case (opcode)
            OPC_MOV: begin
                if (op_o == OP_MOV_IMM)      kind_o = K_MOV_IMM;
                else if (op_o == OP_MOV_REG) kind_o = K_MOV_REG;
            end
            OPC_ALU: begin
                case (op_o)
                    OP_ADD, OP_AND: kind_o = K_ALU_AB;
                    OP_CMP:         kind_o = K_CMP;
                    OP_MVN:         kind_o = K_MVN;
                    default:        kind_o = K_ILLEGAL;
                endcase
            end
            default: kind_o = K_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/datapath_ctrl_fsm.sv
// datapath_ctrl_fsm: sequencer for the register-file/shifter/ALU datapath.
// Accepts one instruction per s/w handshake and drives the datapath control
// inputs one micro-step per clock (Moore outputs from state + IR).
// Ports:
//   clk, reset            clock; asynchronous active-high reset (forces WAIT)
//   s, instr              start strobe (sampled in WAIT only) and instruction
//   w, illegal            ready (WAIT) and 1-cycle unsupported-instruction pulse
//   vsel, writenum, write register-file write mux/address/enable
//   readnum               register-file read address
//   loada, loadb          A / B pipeline register loads
//   shift, asel, bsel     shifter op and ALU operand selects
//   ALUop, loadc, loads   ALU op, C and status register loads
//   datapath_in           sign-extended imm8 of the latched instruction
module datapath_ctrl_fsm
    import datapath_ctrl_fsm_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [15:0]   instr,
    output logic          w,
    output logic          illegal,
    output logic          vsel,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic [RW-1:0] readnum,
    output logic          loada,
    output logic          loadb,
    output logic [1:0]    shift,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    ALUop,
    output logic          loadc,
    output logic          loads,
    output logic [DW-1:0] datapath_in
);

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic [1:0]  op;
    logic [2:0]  rn, rd, rm;
    logic [1:0]  sh;
    kind_e       kind;

    instr_decode #(.DW(DW)) u_instr_decode (
        .ir_i     (ir_q),
        .op_o     (op),
        .rn_o     (rn),
        .rd_o     (rd),
        .sh_o     (sh),
        .rm_o     (rm),
        .imm_sx_o (datapath_in),
        .kind_o   (kind)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: IR is a single register, so it is cleared on reset too;
            // datapath_in then reads 0 instead of a stale immediate.
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            // NOTE: non-blocking so state and IR both update from pre-edge values.
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d  = state_q;
        ir_d     = ir_q;
        w        = 1'b0;
        illegal  = 1'b0;
        vsel     = 1'b0;
        writenum = '0;
        write    = 1'b0;
        readnum  = '0;
        loada    = 1'b0;
        loadb    = 1'b0;
        shift    = SH_NONE;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = ALU_ADD;
        loadc    = 1'b0;
        loads    = 1'b0;

        case (state_q)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (kind)
                    K_MOV_IMM:        state_d = S_WR_IMM;
                    K_MOV_REG, K_MVN: state_d = S_GET_B;
                    K_ALU_AB, K_CMP:  state_d = S_GET_A;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_WAIT;
                    end
                endcase
            end
            S_GET_A: begin
                readnum = RW'(rn);
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = RW'(rm);
                loadb   = 1'b1;
                state_d = (kind == K_CMP) ? S_CMP : S_ALU;
            end
            S_ALU: begin
                shift = sh;
                loadc = 1'b1;
                if (kind == K_MOV_REG) begin
                    // MOV reg passes the shifted B through as 0 + B.
                    ALUop = ALU_ADD;
                    asel  = 1'b1;
                end else begin
                    // ADD/AND/MVN op codes coincide with their ALU codes.
                    ALUop = op;
                end
                state_d = S_WR_REG;
            end
            S_CMP: begin
                shift   = sh;
                ALUop   = ALU_SUB;
                loads   = 1'b1;
                state_d = S_WAIT;
            end
            S_WR_REG: begin
                vsel     = 1'b0;
                writenum = RW'(rd);
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            S_WR_IMM: begin
                vsel     = 1'b1;
                writenum = RW'(rn);
                write    = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

endmodule
